// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared defaults, FSM encoding and RGB packing for the HUB75 receiver
// Purpose: common definitions imported by hub75_rx and hub75_line_bank.
// Contents: geometry defaults, receiver FSM state type, {R,G,B} pixel packing helper.
package hub75_pkg;

  localparam int COLS_DEF     = 64;
  localparam int ROW_BITS_DEF = 4;
  localparam int CW_DEF       = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCHED = 2'd2
  } state_t;

  // Pixels are always carried as {R,G,B}, R in the MSB.
  function automatic logic [2:0] pack_rgb(input logic r, input logic g, input logic b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/hub75_line_bank.sv
// rtl/hub75_line_bank.sv - one half-panel line store with full-line write and registered pixel read
// Purpose: 2**ROW_BITS lines of COLS pixels; a whole line is written at once, one pixel read per cycle.
// Ports:
//   clk, rst           clock, synchronous active-low reset (read register only)
//   we, waddr, wdata   full-line write; wdata column c at bits [3c+2:3c]
//   rd_en, raddr, rcol pixel read request
//   rd_rgb             registered {R,G,B}, updated only on rd_en; 0 for rcol >= COLS
module hub75_line_bank
  import hub75_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ROW_BITS-1:0]   waddr,
  input  logic [COLS*3-1:0]     wdata,
  input  logic                  rd_en,
  input  logic [ROW_BITS-1:0]   raddr,
  input  logic [CW-1:0]         rcol,
  output logic [2:0]            rd_rgb
);

  // Storage is not reset; lines are undefined until first latched.
  logic [2:0] mem [2**ROW_BITS][COLS];
  logic       col_ok;

  assign col_ok = ({1'b0, rcol} < (CW+1)'(COLS));

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < COLS; c++) begin
        mem[waddr][c] <= wdata[c*3 +: 3];
      end
    end
  end

  // Read samples the array before this edge's write lands, so a same-row
  // read and latch return the previous line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_rgb <= 3'b000;
    end else if (rd_en) begin
      rd_rgb <= col_ok ? mem[raddr][rcol] : 3'b000;
    end
  end

endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel emulator: shifts RGB lines, latches them into a frame store
// Purpose: loopback sink for the matrix driver; behaves like an LED panel with a readable frame store.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   A,B,C,D                  row address (A = LSB)
//   R0,G0,B0 / R1,G1,B1      upper / lower half pixel data
//   OE, LAT                  shift qualifier, line latch strobe
//   rd_en, rd_row, rd_col    frame-store read (rd_row MSB selects lower half)
//   rd_rgb, rd_valid         read data, valid one cycle after rd_en
//   line_done, frame_done    pulses after each latch / after latching the last row
//   frame_cnt                completed frame count (wraps)
//   short_line, clr_status   sticky under-shifted latch flag and its clear
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A,
  input  logic                B,
  input  logic                C,
  input  logic                D,
  input  logic                R0,
  input  logic                G0,
  input  logic                B0,
  input  logic                R1,
  input  logic                G1,
  input  logic                B1,
  input  logic                OE,
  input  logic                LAT,
  input  logic                rd_en,
  input  logic [ROW_BITS:0]   rd_row,
  input  logic [CW-1:0]       rd_col,
  output logic [2:0]          rd_rgb,
  output logic                rd_valid,
  output logic                line_done,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic                short_line,
  input  logic                clr_status
);

  state_t                state, state_nx;
  logic                  lat_q;
  logic [CW:0]           cnt;
  logic                  shift_go, latch_go;
  logic [ROW_BITS-1:0]   row;
  logic                  last_row;
  logic [COLS*3-1:0]     sh_top, sh_bot;
  logic                  rd_sel;
  logic [2:0]            top_rgb, bot_rgb;

  assign row      = {D, C, B, A};
  assign last_row = &row;

  always_comb begin
    state_nx = state;
    shift_go = rst & OE & ~LAT;
    latch_go = rst & LAT & ~lat_q;
    case (state)
      ST_IDLE, ST_SHIFT: begin
        if (latch_go)      state_nx = ST_LATCHED;
        else if (shift_go) state_nx = ST_SHIFT;
      end
      ST_LATCHED: begin
        if (!LAT) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Newest pixel enters at column COLS-1; older pixels move toward column 0
  // and fall off the end, so the last COLS shifts always form the line.
  always_ff @(posedge clk) begin
    if (shift_go) begin
      sh_top <= {pack_rgb(R0, G0, B0), sh_top[COLS*3-1:3]};
      sh_bot <= {pack_rgb(R1, G1, B1), sh_bot[COLS*3-1:3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lat_q      <= 1'b0;
      cnt        <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      short_line <= 1'b0;
      rd_valid   <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      state      <= state_nx;
      lat_q      <= LAT;
      line_done  <= latch_go;
      frame_done <= latch_go & last_row;
      if (latch_go && last_row) frame_cnt <= frame_cnt + 16'd1;

      if (latch_go)                               cnt <= '0;
      else if (shift_go && cnt != (CW+1)'(COLS))  cnt <= cnt + 1'b1;

      // A short latch in the same cycle as a clear keeps the flag set.
      if (latch_go && cnt < (CW+1)'(COLS)) short_line <= 1'b1;
      else if (clr_status)                 short_line <= 1'b0;

      rd_valid <= rd_en;
      if (rd_en) rd_sel <= rd_row[ROW_BITS];
    end
  end

  hub75_line_bank #(.COLS(COLS), .ROW_BITS(ROW_BITS), .CW(CW)) u_top (
    .clk    (clk),
    .rst    (rst),
    .we     (latch_go),
    .waddr  (row),
    .wdata  (sh_top),
    .rd_en  (rd_en & ~rd_row[ROW_BITS]),
    .raddr  (rd_row[ROW_BITS-1:0]),
    .rcol   (rd_col),
    .rd_rgb (top_rgb)
  );

  hub75_line_bank #(.COLS(COLS), .ROW_BITS(ROW_BITS), .CW(CW)) u_bot (
    .clk    (clk),
    .rst    (rst),
    .we     (latch_go),
    .waddr  (row),
    .wdata  (sh_bot),
    .rd_en  (rd_en & rd_row[ROW_BITS]),
    .raddr  (rd_row[ROW_BITS-1:0]),
    .rcol   (rd_col),
    .rd_rgb (bot_rgb)
  );

  assign rd_rgb = rd_sel ? bot_rgb : top_rgb;

endmodule
